// File: rtl/fp64_product_capture_fifo.sv
// fp64_product_capture_fifo
//   Capture stage that sits behind the combinational fp64 multiplier. Each
//   product offered on the input handshake is classified (NaN, Inf, zero,
//   subnormal, or normal) and stored together with its class in a small
//   first-word-fall-through FIFO. Products offered while the FIFO is full are
//   refused, and a saturating counter records how many were refused.
//
// Parameters
//   DEPTH  FIFO entries (power of two, >= 2)
//   W      product width; classification assumes IEEE-754 binary64 (64)
//
// Ports
//   clk         system clock, rising edge
//   rst         synchronous active-high reset
//   in_valid    in_product carries a product to capture
//   in_ready    FIFO can accept a product this cycle
//   in_product  multiplier final product
//   out_valid   head entry available
//   out_ready   consumer takes the head entry this cycle
//   out_data    head product
//   out_class   head class {nan,inf,zero,sub}; all zero means normal
//   count       number of entries held
//   drop_cnt    saturating count of refused products
module fp64_product_capture_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [W-1:0]             in_product,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [W-1:0]             out_data,
  output logic [3:0]               out_class,
  output logic [$clog2(DEPTH):0]   count,
  output logic [7:0]               drop_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  logic [W-1:0]  data_mem  [DEPTH];
  logic [3:0]    class_mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;

  logic [10:0] exp_field;
  logic [51:0] frac_field;
  logic        exp_max;
  logic        exp_zero;
  logic        frac_zero;
  logic [3:0]  in_class;
  logic        push;
  logic        pop;

  // Classification works on the raw exponent/fraction fields; the sign bit
  // plays no part, so -0 is zero and -Inf is Inf.
  assign exp_field  = in_product[62:52];
  assign frac_field = in_product[51:0];
  assign exp_max    = (exp_field == 11'h7FF);
  assign exp_zero   = (exp_field == 11'h000);
  assign frac_zero  = (frac_field == 52'd0);
  assign in_class   = {exp_max & ~frac_zero,
                       exp_max &  frac_zero,
                       exp_zero & frac_zero,
                       exp_zero & ~frac_zero};

  // Flow control comes purely from the registered occupancy, so in_ready has
  // no combinational dependence on out_ready. A full FIFO refuses the
  // product even when the consumer pops on the same edge.
  assign in_ready  = (count != FULL_COUNT);
  assign out_valid = (count != '0);
  assign push      = in_valid & in_ready & ~rst;
  assign pop       = out_valid & out_ready & ~rst;

  // First-word-fall-through: the head entry is always presented directly
  // from storage at the read pointer.
  assign out_data  = data_mem[rd_ptr];
  assign out_class = class_mem[rd_ptr];

  // Storage is deliberately left unreset; the contents only matter while
  // out_valid marks them as held.
  always_ff @(posedge clk) begin
    if (push) begin
      data_mem[wr_ptr]  <= in_product;
      class_mem[wr_ptr] <= in_class;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two. Occupancy only
  // moves when exactly one of push/pop happens.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  // Refused products are counted once per cycle and the counter sticks at
  // its maximum until the next reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      drop_cnt <= 8'd0;
    end else if (in_valid && !in_ready && drop_cnt != 8'hFF) begin
      drop_cnt <= drop_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_fp64_product_capture_fifo.sv
// tb_fp64_product_capture_fifo
//   Directed and randomized stimulus for fp64_product_capture_fifo, checked
//   against a queue-based reference model of the FIFO and the field-based
//   classification rules.
module tb_fp64_product_capture_fifo;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_product;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_data;
  logic [3:0]  out_class;
  logic [2:0]  count;
  logic [7:0]  drop_cnt;

  int test_count = 0;
  int fail_count = 0;

  logic [67:0] model_q[$];
  int          model_drops = 0;

  fp64_product_capture_fifo #(.DEPTH(4), .W(64)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_product(in_product),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_class (out_class),
    .count     (count),
    .drop_cnt  (drop_cnt)
  );

  // Free-running clock, period 10.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference classification straight from the exponent/fraction rules.
  function automatic logic [3:0] ref_class(input logic [63:0] p);
    int unsigned     e;
    longint unsigned f;
    logic nan_b, inf_b, zero_b, sub_b;
    e      = int'((p >> 52) & 64'h7FF);
    f      = p & 64'h000F_FFFF_FFFF_FFFF;
    nan_b  = (e == 2047) && (f != 0);
    inf_b  = (e == 2047) && (f == 0);
    zero_b = (e == 0) && (f == 0);
    sub_b  = (e == 0) && (f != 0);
    return {nan_b, inf_b, zero_b, sub_b};
  endfunction

  // Random product biased toward the special exponent values.
  function automatic logic [63:0] rand_product();
    logic [63:0] p;
    p = {$urandom, $urandom};
    case ($urandom_range(0, 4))
      0: p[62:52] = 11'h7FF;
      1: p[62:52] = 11'h000;
      default: ;
    endcase
    if ($urandom_range(0, 2) == 0) p[51:0] = 52'd0;
    return p;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    test_count++;
    assert (obs === expv) else begin
      fail_count++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Compares every visible output against the model's current state.
  task automatic checkOutput();
    logic [67:0] head;
    check("in_ready", 64'(in_ready), 64'(model_q.size() != 4));
    check("out_valid", 64'(out_valid), 64'(model_q.size() != 0));
    check("count", 64'(count), 64'(model_q.size()));
    check("drop_cnt", 64'(drop_cnt), 64'(model_drops));
    if (model_q.size() != 0) begin
      head = model_q[0];
      check("out_data", out_data, head[63:0]);
      check("out_class", 64'(out_class), 64'(head[67:64]));
    end
  endtask

  // Drives one cycle of inputs, checks the outputs held from the previous
  // edge, then advances the model for the coming edge.
  task automatic applyStimulus(input logic iv, input logic [63:0] prod, input logic ordy);
    bit ready_m;
    @(negedge clk);
    in_valid   = iv;
    in_product = prod;
    out_ready  = ordy;
    checkOutput();
    ready_m = (model_q.size() != 4);
    if (ordy && model_q.size() != 0) void'(model_q.pop_front());
    if (iv && ready_m) model_q.push_back({ref_class(prod), prod});
    if (iv && !ready_m && model_drops < 255) model_drops++;
  endtask

  // Holds rst for one edge with the given handshake inputs, then idles.
  task automatic apply_reset(input logic iv, input logic ordy);
    @(negedge clk);
    rst        = 1'b1;
    in_valid   = iv;
    out_ready  = ordy;
    in_product = 64'h3FF0_0000_0000_0000;
    @(negedge clk);
    rst       = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    model_q.delete();
    model_drops = 0;
  endtask

  task automatic sample_after_edge();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [63:0] specials [4];
    logic [3:0]  exp_cls  [4];
    logic [63:0] seq_val;

    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_product = '0;
    specials = '{64'h7FF8_0000_0000_0000, 64'hFFF0_0000_0000_0000,
                 64'h8000_0000_0000_0000, 64'h0000_0000_0000_0001};
    exp_cls  = '{4'b1000, 4'b0100, 4'b0010, 4'b0001};

    // Reset state and a single normal product.
    apply_reset(1'b0, 1'b0);
    check("rst_count", 64'(count), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_drop_cnt", 64'(drop_cnt), 64'd0);
    applyStimulus(1'b1, 64'h4000_0000_0000_0000, 1'b0);
    sample_after_edge();
    check("t1_out_valid", 64'(out_valid), 64'd1);
    check("t1_out_data", out_data, 64'h4000_0000_0000_0000);
    check("t1_out_class", 64'(out_class), 64'd0);
    check("t1_count", 64'(count), 64'd1);

    // Each special class in turn.
    apply_reset(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, specials[i], 1'b0);
    for (int i = 0; i < 4; i++) begin
      sample_after_edge();
      check("t2_class_order", 64'(out_class), 64'(exp_cls[i]));
      applyStimulus(1'b0, 64'd0, 1'b1);
    end
    applyStimulus(1'b0, 64'd0, 1'b0);

    // Overfill: four pushes, two refusals.
    apply_reset(1'b0, 1'b0);
    for (int i = 0; i < 6; i++) applyStimulus(1'b1, 64'h4010_0000_0000_0000 + 64'(i), 1'b0);
    sample_after_edge();
    check("t3_count", 64'(count), 64'd4);
    check("t3_in_ready", 64'(in_ready), 64'd0);
    check("t3_drop_cnt", 64'(drop_cnt), 64'd2);

    // Full with simultaneous offer and pop: pop only, then push next cycle.
    applyStimulus(1'b1, 64'h4020_0000_0000_0000, 1'b1);
    sample_after_edge();
    check("t4_count_after_pop", 64'(count), 64'd3);
    applyStimulus(1'b1, 64'h4030_0000_0000_0000, 1'b0);
    sample_after_edge();
    check("t4_count_after_push", 64'(count), 64'd4);
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 64'd0, 1'b1);

    // Streaming with both sides always ready; pointers wrap several times.
    apply_reset(1'b0, 1'b0);
    seq_val = 64'h3FF0_0000_0000_0000;
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b1, seq_val, 1'b1);
      seq_val = seq_val + 64'd1;
    end
    applyStimulus(1'b0, 64'd0, 1'b1);
    sample_after_edge();
    check("t5_drop_cnt", 64'(drop_cnt), 64'd0);

    // Randomized traffic.
    for (int i = 0; i < 400; i++)
      applyStimulus(1'(($urandom & 32'h3) != 0), rand_product(), 1'(($urandom & 32'h3) == 0 ? 0 : $urandom & 1));

    // Mid-transfer reset followed by drop counter saturation.
    apply_reset(1'b0, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, rand_product(), 1'b0);
    apply_reset(1'b1, 1'b1);
    check("t6_count", 64'(count), 64'd0);
    check("t6_out_valid", 64'(out_valid), 64'd0);
    check("t6_drop_cnt", 64'(drop_cnt), 64'd0);
    check("t6_in_ready", 64'(in_ready), 64'd1);
    for (int i = 0; i < 304; i++) applyStimulus(1'b1, rand_product(), 1'b0);
    sample_after_edge();
    check("t6_drop_sat", 64'(drop_cnt), 64'd255);
    applyStimulus(1'b1, 64'd0, 1'b0);
    sample_after_edge();
    check("t6_drop_hold", 64'(drop_cnt), 64'd255);

    $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
    $finish;
  end

endmodule
